spi_ram_arbiter: RTL and testbench

//   Shares one mapped SPI RAM controller (word-addressed, strobe rd/wr, rbusy/wbusy)

---
 rtl/spi_ram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: two-master front end for a word-addressed SPI RAM controller.
// Each port captures one strobe at a time. A round-robin FSM then runs one
// downstream transaction at a time: IDLE -> ISSUE -> WAIT -> DONE.
// A watchdog ends any transaction whose busy flag stays high too long.
module spi_ram_arbiter #(
  parameter int AW      = 20,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic          p0_rd,
  input  logic          p0_wr,
  output logic          p0_rbusy,
  output logic          p0_wbusy,
  output logic [DW-1:0] p0_rdata,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  input  logic          p1_rd,
  input  logic          p1_wr,
  output logic          p1_rbusy,
  output logic          p1_wbusy,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_rd,
  output logic          ram_wr,
  input  logic          ram_rbusy,
  input  logic          ram_wbusy,
  input  logic [DW-1:0] ram_rdata,
  output logic          timeout_err,
  output logic          proto_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  // The watchdog counts 0..TIMEOUT-1 and fires on the last count.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WD_MAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [DW-1:0] TIMEOUT_DATA = DW'(32'hDEAD_BEEF);

  state_t        state;
  logic [1:0]    pend;
  logic [1:0]    dir_wr;
  logic [AW-1:0] slot_addr  [2];
  logic [DW-1:0] slot_wdata [2];
  logic [DW-1:0] rdata_q    [2];
  logic          grant;
  logic          last_grant;
  logic [CW-1:0] wd_cnt;

  logic [1:0]    req_rd;
  logic [1:0]    req_wr;
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];
  logic          next_grant;
  logic          busy_sel;
  logic          wd_fire;
  logic          finish;

  assign req_rd       = {p1_rd, p0_rd};
  assign req_wr       = {p1_wr, p0_wr};
  assign req_addr[0]  = p0_addr;
  assign req_addr[1]  = p1_addr;
  assign req_wdata[0] = p0_wdata;
  assign req_wdata[1] = p1_wdata;

  assign p0_rbusy = pend[0] & ~dir_wr[0];
  assign p0_wbusy = pend[0] &  dir_wr[0];
  assign p1_rbusy = pend[1] & ~dir_wr[1];
  assign p1_wbusy = pend[1] &  dir_wr[1];
  assign p0_rdata = rdata_q[0];
  assign p1_rdata = rdata_q[1];

  // Arbitration, the downstream busy for the granted direction, and the end of WAIT.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    next_grant = pend[1];
    if (&pend) next_grant = ~last_grant;
    busy_sel = dir_wr[grant] ? ram_wbusy : ram_rbusy;
    wd_fire  = (TIMEOUT != 0) && (wd_cnt == WD_MAX);
    finish   = (state == S_WAIT) && (!busy_sel || wd_fire);
  end

  // Per-port request capture: set pend on an accepted strobe, clear it when the transaction ends.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend      <= '0;
      dir_wr    <= '0;
      proto_err <= 1'b0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        // NOTE: non-blocking assignments here, so all flops see pre-edge values and the edge order does not matter.
        if (finish && (grant == n[0])) pend[n] <= 1'b0;
        if (req_rd[n] || req_wr[n]) begin
          if (pend[n]) begin
            proto_err <= 1'b1;
          end else begin
            pend[n]   <= 1'b1;
            dir_wr[n] <= ~req_rd[n];
            if (req_rd[n] && req_wr[n]) proto_err <= 1'b1;
          end
        end
      end
    end
  end

  // Slot payload registers: only read while pend is set, so they carry no reset.
  // NOTE: storage read only under a valid flag needs no reset; the flag is the reset state.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if ((req_rd[n] || req_wr[n]) && !pend[n]) begin
        slot_addr[n] <= req_addr[n];
        if (!req_rd[n]) slot_wdata[n] <= req_wdata[n];
      end
    end
  end

  // Transaction sequencer with registered downstream strobes, read data and watchdog.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_rd      <= 1'b0;
      ram_wr      <= 1'b0;
      wd_cnt      <= '0;
      rdata_q[0]  <= '0;
      rdata_q[1]  <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (|pend) begin
            grant      <= next_grant;
            last_grant <= next_grant;
            ram_addr   <= slot_addr[next_grant];
            ram_wdata  <= slot_wdata[next_grant];
            ram_rd     <= ~dir_wr[next_grant];
            ram_wr     <=  dir_wr[next_grant];
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ram_rd <= 1'b0;
          ram_wr <= 1'b0;
          wd_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (!busy_sel) begin
            if (!dir_wr[grant]) rdata_q[grant] <= ram_rdata;
            state <= S_DONE;
          end else if (wd_fire) begin
            rdata_q[grant] <= TIMEOUT_DATA;
            timeout_err    <= 1'b1;
            state          <= S_DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Scoreboard bench for spi_ram_arbiter: stimulus pushes the expected downstream
// transactions and per-port completions. A monitor pops and compares them as the DUT
// presents ram strobes and falling busy flags. A behavioural RAM model answers requests.
module tb_spi_ram_arbiter;
  localparam int AW = 20;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_rd = 1'b0, p0_wr = 1'b0, p1_rd = 1'b0, p1_wr = 1'b0;
  logic          p0_rbusy, p0_wbusy, p1_rbusy, p1_wbusy;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_rd, ram_wr;
  logic          ram_rbusy = 1'b0, ram_wbusy = 1'b0;
  logic [DW-1:0] ram_rdata = '0;
  logic          timeout_err, proto_err;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rd(p0_rd), .p0_wr(p0_wr),
    .p0_rbusy(p0_rbusy), .p0_wbusy(p0_wbusy), .p0_rdata(p0_rdata),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rd(p1_rd), .p1_wr(p1_wr),
    .p1_rbusy(p1_rbusy), .p1_wbusy(p1_wbusy), .p1_rdata(p1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_rbusy(ram_rbusy), .ram_wbusy(ram_wbusy), .ram_rdata(ram_rdata),
    .timeout_err(timeout_err), .proto_err(proto_err)
  );

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } ram_txn_t;

  typedef struct packed {
    logic          is_rd;
    logic [DW-1:0] data;
  } rsp_t;

  ram_txn_t exp_ram[$];
  rsp_t     exp_rsp0[$];
  rsp_t     exp_rsp1[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // ---------------- RAM model ----------------
  int  lat = 5;
  bit  hang = 1'b0;
  int  busy_left = 0;
  bit  busy_is_wr = 1'b0;
  logic [DW-1:0] mem [logic [AW-1:0]];

  // Busy is raised at the strobe and held so WAIT sees exactly lat busy cycles.
  always @(negedge clk) begin
    if (!resetn) begin
      busy_left = 0;
    end else if (ram_rd || ram_wr) begin
      check("ram_no_overlap", busy_left > 0, 0);
      busy_is_wr = ram_wr;
      busy_left  = hang ? (1 << 20) : lat + 1;
      if (ram_wr) mem[ram_addr] = ram_wdata;
      else ram_rdata = mem.exists(ram_addr) ? mem[ram_addr] : '0;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    if (!hang && busy_left > 1000) busy_left = 0;
    ram_rbusy = (busy_left > 0) && !busy_is_wr;
    ram_wbusy = (busy_left > 0) &&  busy_is_wr;
  end

  // ---------------- monitor ----------------
  logic [1:0] rb_prev = '0, wb_prev = '0;

  task automatic port_done(input int p, input logic is_rd, input logic [DW-1:0] data);
    rsp_t r;
    if (p == 0) begin
      check("p0_completion_expected", exp_rsp0.size() != 0, 1);
      if (exp_rsp0.size() == 0) return;
      r = exp_rsp0.pop_front();
    end else begin
      check("p1_completion_expected", exp_rsp1.size() != 0, 1);
      if (exp_rsp1.size() == 0) return;
      r = exp_rsp1.pop_front();
    end
    check(p == 0 ? "p0_completion_dir" : "p1_completion_dir", is_rd, r.is_rd);
    if (is_rd) check(p == 0 ? "p0_rdata" : "p1_rdata", data, r.data);
  endtask

  always @(negedge clk) begin
    ram_txn_t t;
    if (!resetn) begin
      rb_prev = '0;
      wb_prev = '0;
    end else begin
      if (ram_rd || ram_wr) begin
        check("ram_rd_wr_exclusive", ram_rd && ram_wr, 0);
        check("ram_txn_expected", exp_ram.size() != 0, 1);
        if (exp_ram.size() != 0) begin
          t = exp_ram.pop_front();
          check("ram_dir", ram_wr, t.wr);
          check("ram_addr", ram_addr, t.addr);
          if (t.wr) check("ram_wdata", ram_wdata, t.wdata);
        end
      end
      if (rb_prev[0] && !p0_rbusy) port_done(0, 1'b1, p0_rdata);
      if (wb_prev[0] && !p0_wbusy) port_done(0, 1'b0, p0_rdata);
      if (rb_prev[1] && !p1_rbusy) port_done(1, 1'b1, p1_rdata);
      if (wb_prev[1] && !p1_wbusy) port_done(1, 1'b0, p1_rdata);
      rb_prev = {p1_rbusy, p0_rbusy};
      wb_prev = {p1_wbusy, p0_wbusy};
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a negedge with strobes set; holds them one cycle.
  task automatic end_strobe();
    @(negedge clk);
    p0_rd = 1'b0; p0_wr = 1'b0; p1_rd = 1'b0; p1_wr = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((p0_rbusy || p0_wbusy || p1_rbusy || p1_wbusy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", n < budget, 1);
    repeat (2) @(negedge clk);
  endtask

  // Returns the posedge count from the strobe edge until p0 busy is seen low.
  task automatic p0_latency(output int n);
    n = 1;
    while ((p0_rbusy || p0_wbusy) && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    exp_ram.delete();
    exp_rsp0.delete();
    exp_rsp1.delete();
    resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit got=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int  n;
    bit  seen;
    mem[20'h00010] = 32'h1234_5678;

    repeat (3) @(negedge clk);
    // Reset state
    check("rst_p0_busy", {p0_rbusy, p0_wbusy}, 0);
    check("rst_p1_busy", {p1_rbusy, p1_wbusy}, 0);
    check("rst_ram_strobes", {ram_rd, ram_wr}, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_rdata", {p0_rdata, p1_rdata}, 0);
    check("rst_errors", {timeout_err, proto_err}, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Uncontended read, 5-cycle downstream busy
    lat = 5;
    exp_ram.push_back('{1'b0, 20'h00010, 32'h0});
    exp_rsp0.push_back('{1'b1, 32'h1234_5678});
    p0_addr = 20'h00010; p0_rd = 1'b1;
    end_strobe();
    check("t1_rbusy_next_cycle", p0_rbusy, 1);
    p0_latency(n);
    check("t1_latency", n, 9);
    check("t1_no_errors", {timeout_err, proto_err}, 0);
    wait_idle(20);

    // Simultaneous writes after reset: port 0 first, then port 1
    do_reset();
    exp_ram.push_back('{1'b1, 20'h00100, 32'hA0A0_A0A0});
    exp_ram.push_back('{1'b1, 20'h00200, 32'hB1B1_B1B1});
    exp_rsp0.push_back('{1'b0, 32'h0});
    exp_rsp1.push_back('{1'b0, 32'h0});
    p0_addr = 20'h00100; p0_wdata = 32'hA0A0_A0A0; p0_wr = 1'b1;
    p1_addr = 20'h00200; p1_wdata = 32'hB1B1_B1B1; p1_wr = 1'b1;
    end_strobe();
    check("t2_both_wbusy", {p1_wbusy, p0_wbusy}, 2'b11);
    wait_idle(60);
    // A solo port-0 transaction leaves last_grant=0, so the next tie goes to port 1
    exp_ram.push_back('{1'b0, 20'h00100, 32'h0});
    exp_rsp0.push_back('{1'b1, 32'hA0A0_A0A0});
    p0_addr = 20'h00100; p0_rd = 1'b1;
    end_strobe();
    wait_idle(30);
    exp_ram.push_back('{1'b0, 20'h00100, 32'h0});
    exp_ram.push_back('{1'b0, 20'h00200, 32'h0});
    exp_rsp1.push_back('{1'b1, 32'hA0A0_A0A0});
    exp_rsp0.push_back('{1'b1, 32'hB1B1_B1B1});
    p0_addr = 20'h00200; p0_rd = 1'b1;
    p1_addr = 20'h00100; p1_rd = 1'b1;
    end_strobe();
    wait_idle(60);

    // p1 read queued behind an active p0 write
    exp_ram.push_back('{1'b1, 20'h00300, 32'hC3C3_C3C3});
    exp_rsp0.push_back('{1'b0, 32'h0});
    p0_addr = 20'h00300; p0_wdata = 32'hC3C3_C3C3; p0_wr = 1'b1;
    end_strobe();
    repeat (2) @(negedge clk);
    exp_ram.push_back('{1'b0, 20'h00300, 32'h0});
    exp_rsp1.push_back('{1'b1, 32'hC3C3_C3C3});
    p1_addr = 20'h00300; p1_rd = 1'b1;
    end_strobe();
    check("t3_p1_queued", p1_rbusy, 1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ram_rd) begin
        seen = 1'b1;
        check("t3_rd_after_wbusy_falls", p0_wbusy, 0);
      end
    end
    check("t3_ram_rd_seen", seen, 1);
    wait_idle(30);

    // Second strobe while pending is ignored
    check("t4_proto_clear_before", proto_err, 0);
    exp_ram.push_back('{1'b0, 20'h00010, 32'h0});
    exp_rsp0.push_back('{1'b1, 32'h1234_5678});
    p0_addr = 20'h00010; p0_rd = 1'b1;
    end_strobe();
    repeat (2) @(negedge clk);
    p0_addr = 20'h00300; p0_rd = 1'b1;
    end_strobe();
    check("t4_proto_err", proto_err, 1);
    wait_idle(30);

    // Watchdog: downstream busy stuck high
    check("t5_timeout_clear_before", timeout_err, 0);
    hang = 1'b1;
    exp_ram.push_back('{1'b0, 20'h00040, 32'h0});
    exp_rsp0.push_back('{1'b1, 32'hDEAD_BEEF});
    p0_addr = 20'h00040; p0_rd = 1'b1;
    end_strobe();
    p0_latency(n);
    check("t5_timeout_latency", n, 11);
    check("t5_timeout_err", timeout_err, 1);
    hang = 1'b0;
    repeat (2) @(negedge clk);
    exp_ram.push_back('{1'b0, 20'h00010, 32'h0});
    exp_rsp1.push_back('{1'b1, 32'h1234_5678});
    p1_addr = 20'h00010; p1_rd = 1'b1;
    end_strobe();
    wait_idle(30);
    check("t5_errors_sticky", {timeout_err, proto_err}, 2'b11);

    // rd and wr in the same cycle: read wins, proto_err set
    do_reset();
    check("t6_errors_cleared_by_reset", {timeout_err, proto_err}, 0);
    exp_ram.push_back('{1'b0, 20'h00010, 32'h0});
    exp_rsp1.push_back('{1'b1, 32'h1234_5678});
    p1_addr = 20'h00010; p1_wdata = 32'hFFFF_FFFF; p1_rd = 1'b1; p1_wr = 1'b1;
    end_strobe();
    check("t6_rd_wins", {p1_rbusy, p1_wbusy}, 2'b10);
    check("t6_proto_err", proto_err, 1);
    wait_idle(30);

    // Reset asserted during WAIT
    do_reset();
    exp_ram.push_back('{1'b0, 20'h00010, 32'h0});
    p0_addr = 20'h00010; p0_rd = 1'b1;
    end_strobe();
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("t7_busy_cleared", {p0_rbusy, p0_wbusy, p1_rbusy, p1_wbusy}, 0);
    check("t7_strobes_cleared", {ram_rd, ram_wr}, 0);
    @(negedge clk);
    do_reset();
    exp_ram.push_back('{1'b0, 20'h00010, 32'h0});
    exp_rsp0.push_back('{1'b1, 32'h1234_5678});
    p0_addr = 20'h00010; p0_rd = 1'b1;
    end_strobe();
    p0_latency(n);
    check("t7_post_reset_latency", n, 9);
    wait_idle(20);

    check("exp_ram_drained", exp_ram.size(), 0);
    check("exp_rsp_drained", exp_rsp0.size() + exp_rsp1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
